// File: rtl/decode_controller.sv
// Registered RISC-V decode stage with a 2-entry skid buffer so O_ready stays registered.
// Optional illegal-opcode detection is enabled by defining DECODE_ILLEGAL_EN.
module decode_controller (
   input  logic        I_clk,
   input  logic        I_rst,
   input  logic        I_valid,
   output logic        O_ready,
   input  logic [31:0] I_instr,
   input  logic [31:0] I_pc,
   input  logic        I_flush,
   output logic        O_valid,
   input  logic        I_ready,
   output logic [31:0] O_instr,
   output logic [31:0] O_pc,
   output logic [2:0]  O_immsel,
   output logic        O_useimm,
   output logic        O_regwrite,
   output logic [4:0]  O_rs1,
   output logic [4:0]  O_rs2,
   output logic [4:0]  O_rd,
   output logic        O_illegal
);

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_U = 3'b011;
   localparam logic [2:0] IMM_J = 3'b100;
   localparam logic [2:0] IMM_R = 3'b101;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_ONE,
      ST_FULL
   } state_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [2:0]  immsel;
      logic        useimm;
      logic        regwrite;
`ifdef DECODE_ILLEGAL_EN
      logic        illegal;
`endif
   } entry_t;

   state_t state;
   entry_t main_q;
   entry_t skid_q;
   entry_t dec;
   logic   accept;
   logic   issue;

   assign accept = I_valid & O_ready;
   assign issue  = O_valid & I_ready;

   always_comb begin
      dec       = '0;
      dec.instr = I_instr;
      dec.pc    = I_pc;
      case (I_instr[6:0])
         OP_LUI, OP_AUIPC: begin
            dec.immsel   = IMM_U;
            dec.useimm   = 1'b1;
            dec.regwrite = 1'b1;
         end
         OP_JAL: begin
            dec.immsel   = IMM_J;
            dec.useimm   = 1'b1;
            dec.regwrite = 1'b1;
         end
         OP_JALR, OP_LOAD, OP_SYSTEM: begin
            dec.immsel   = IMM_I;
            dec.useimm   = 1'b1;
            dec.regwrite = 1'b1;
         end
         OP_STORE: begin
            dec.immsel   = IMM_S;
            dec.useimm   = 1'b1;
         end
         OP_BRANCH: begin
            dec.immsel   = IMM_B;
         end
         OP_IMM: begin
            // slli/srli/srai take a shift amount rather than a full I-immediate
            dec.immsel   = (I_instr[13:12] == 2'b01) ? IMM_R : IMM_I;
            dec.useimm   = 1'b1;
            dec.regwrite = 1'b1;
         end
         OP_OP: begin
            dec.immsel   = IMM_I;
            dec.regwrite = 1'b1;
         end
         default: begin
            // every listed opcode ends in 2'b11, so this also covers bad low bits
`ifdef DECODE_ILLEGAL_EN
            dec.illegal  = 1'b1;
`endif
         end
      endcase
      if (I_instr[11:7] == 5'd0) begin
         dec.regwrite = 1'b0;
      end
   end

   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         state   <= ST_EMPTY;
         O_valid <= 1'b0;
         O_ready <= 1'b1;
         main_q  <= '0;
         skid_q  <= '0;
      end else if (I_flush) begin
         state   <= ST_EMPTY;
         O_valid <= 1'b0;
         O_ready <= 1'b1;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (accept) begin
                  main_q  <= dec;
                  state   <= ST_ONE;
                  O_valid <= 1'b1;
                  O_ready <= 1'b1;
               end
            end
            ST_ONE: begin
               if (accept && issue) begin
                  main_q <= dec;
               end else if (accept) begin
                  skid_q  <= dec;
                  state   <= ST_FULL;
                  O_ready <= 1'b0;
               end else if (issue) begin
                  state   <= ST_EMPTY;
                  O_valid <= 1'b0;
               end
            end
            ST_FULL: begin
               if (issue) begin
                  main_q  <= skid_q;
                  state   <= ST_ONE;
                  O_ready <= 1'b1;
               end
            end
            default: begin
               state   <= ST_EMPTY;
               O_valid <= 1'b0;
               O_ready <= 1'b1;
            end
         endcase
      end
   end

   assign O_instr    = main_q.instr;
   assign O_pc       = main_q.pc;
   assign O_immsel   = main_q.immsel;
   assign O_useimm   = main_q.useimm;
   assign O_regwrite = main_q.regwrite;
   assign O_rs1      = main_q.instr[19:15];
   assign O_rs2      = main_q.instr[24:20];
   assign O_rd       = main_q.instr[11:7];
`ifdef DECODE_ILLEGAL_EN
   assign O_illegal  = main_q.illegal;
`else
   assign O_illegal  = 1'b0;
`endif

endmodule

// File: tb/tb_decode_controller.sv
// Scoreboard bench for decode_controller: directed vectors queued on accept, checked on issue.
module tb_decode_controller;

   logic        I_clk = 1'b0;
   logic        I_rst;
   logic        I_valid;
   logic        O_ready;
   logic [31:0] I_instr;
   logic [31:0] I_pc;
   logic        I_flush;
   logic        O_valid;
   logic        I_ready;
   logic [31:0] O_instr;
   logic [31:0] O_pc;
   logic [2:0]  O_immsel;
   logic        O_useimm;
   logic        O_regwrite;
   logic [4:0]  O_rs1;
   logic [4:0]  O_rs2;
   logic [4:0]  O_rd;
   logic        O_illegal;

`ifdef DECODE_ILLEGAL_EN
   localparam logic ILL = 1'b1;
`else
   localparam logic ILL = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [2:0]  immsel;
      logic        useimm;
      logic        regwrite;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        illegal;
   } exp_t;

   exp_t cur_exp;
   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;
   int   issued = 0;

   decode_controller dut (
      .I_clk      (I_clk),
      .I_rst      (I_rst),
      .I_valid    (I_valid),
      .O_ready    (O_ready),
      .I_instr    (I_instr),
      .I_pc       (I_pc),
      .I_flush    (I_flush),
      .O_valid    (O_valid),
      .I_ready    (I_ready),
      .O_instr    (O_instr),
      .O_pc       (O_pc),
      .O_immsel   (O_immsel),
      .O_useimm   (O_useimm),
      .O_regwrite (O_regwrite),
      .O_rs1      (O_rs1),
      .O_rs2      (O_rs2),
      .O_rd       (O_rd),
      .O_illegal  (O_illegal)
   );

   always #5 I_clk = ~I_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: pop on issue, drop on flush/reset, push on accept.
   always @(negedge I_clk) begin
      exp_t e;
      if (I_rst) begin
         sbq.delete();
      end else begin
         if (O_valid && I_ready) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_issue: got instr %h expected nothing at %0t", O_instr, $time);
            end else begin
               e = sbq.pop_front();
               issued++;
               chk("issue_instr", O_instr, e.instr);
               chk("issue_pc", O_pc, e.pc);
               chk("issue_ctrl",
                   {14'd0, O_immsel, O_useimm, O_regwrite, O_rd, O_rs1, O_rs2, O_illegal},
                   {14'd0, e.immsel, e.useimm, e.regwrite, e.rd, e.rs1, e.rs2, e.illegal});
            end
         end
         if (I_flush) sbq.delete();
         else if (I_valid && O_ready) sbq.push_back(cur_exp);
      end
   end

   task automatic step();
      @(posedge I_clk);
      #1;
   endtask

   task automatic offer(input logic [31:0] ins, input logic [31:0] pc, input logic [2:0] imm,
                        input logic ui, input logic rw, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic ill);
      I_valid = 1'b1;
      I_instr = ins;
      I_pc    = pc;
      cur_exp = '{instr: ins, pc: pc, immsel: imm, useimm: ui, regwrite: rw,
                  rd: rd, rs1: rs1, rs2: rs2, illegal: ill};
   endtask

   // hand-decoded vectors
   task automatic o_addi(input logic [31:0] pc); offer(32'h00500093, pc, 3'b000, 1, 1, 5'd1, 5'd0, 5'd5, 0); endtask
   task automatic o_srai(input logic [31:0] pc); offer(32'h4050D093, pc, 3'b101, 1, 1, 5'd1, 5'd1, 5'd5, 0); endtask
   task automatic o_sw  (input logic [31:0] pc); offer(32'h00112023, pc, 3'b001, 1, 0, 5'd0, 5'd2, 5'd1, 0); endtask
   task automatic o_lui (input logic [31:0] pc); offer(32'h123450B7, pc, 3'b011, 1, 1, 5'd1, 5'd8, 5'd3, 0); endtask
   task automatic o_add (input logic [31:0] pc); offer(32'h002081B3, pc, 3'b000, 0, 1, 5'd3, 5'd1, 5'd2, 0); endtask
   task automatic o_jal (input logic [31:0] pc); offer(32'h008000EF, pc, 3'b100, 1, 1, 5'd1, 5'd0, 5'd8, 0); endtask
   task automatic o_lw  (input logic [31:0] pc); offer(32'h0000A283, pc, 3'b000, 1, 1, 5'd5, 5'd1, 5'd0, 0); endtask
   task automatic o_beq (input logic [31:0] pc); offer(32'h00000063, pc, 3'b010, 0, 0, 5'd0, 5'd0, 5'd0, 0); endtask
   task automatic o_bad (input logic [31:0] pc); offer(32'h0000007F, pc, 3'b000, 0, 0, 5'd0, 5'd0, 5'd0, ILL); endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      I_rst = 1'b1; I_valid = 1'b0; I_instr = '0; I_pc = '0;
      I_flush = 1'b0; I_ready = 1'b0; cur_exp = '0;
      step(); step();
      chk("rst_valid", {31'd0, O_valid}, 32'd0);
      chk("rst_ready", {31'd0, O_ready}, 32'd1);
      chk("rst_instr", O_instr, 32'd0);
      chk("rst_ctrl", {20'd0, O_immsel, O_useimm, O_regwrite, O_rd, O_illegal}, 32'd0);
      I_rst = 1'b0;

      // single addi, earliest issue one edge after accept
      I_ready = 1'b1;
      o_addi(32'h1000);
      step();
      I_valid = 1'b0;
      chk("addi_valid", {31'd0, O_valid}, 32'd1);
      step();

      // back-to-back, one per cycle
      o_srai(32'h1004); chk("b2b_ready0", {31'd0, O_ready}, 32'd1); step();
      o_sw  (32'h1008); chk("b2b_ready1", {31'd0, O_ready}, 32'd1); step();
      o_lui (32'h100C); chk("b2b_ready2", {31'd0, O_ready}, 32'd1); step();
      I_valid = 1'b0;
      chk("b2b_valid", {31'd0, O_valid}, 32'd1);
      step();
      chk("b2b_issued", issued, 32'd4);

      // fill to FULL with I_ready low
      I_ready = 1'b0;
      o_add(32'h2000); step();
      o_jal(32'h2004); step();
      o_lw (32'h2008);
      chk("full_ready", {31'd0, O_ready}, 32'd0);
      chk("full_hold0", O_instr, 32'h002081B3);
      step();
      chk("full_ready2", {31'd0, O_ready}, 32'd0);
      chk("full_hold1", O_instr, 32'h002081B3);
      chk("full_hold_rd", {27'd0, O_rd}, 32'd3);
      I_ready = 1'b1;
      step();
      chk("leave_full_ready", {31'd0, O_ready}, 32'd1);
      chk("leave_full_instr", O_instr, 32'h008000EF);
      step();
      I_valid = 1'b0;
      step();
      chk("drain_valid", {31'd0, O_valid}, 32'd0);

      // flush in FULL with an offered instruction
      I_ready = 1'b0;
      o_add(32'h3000); step();
      o_jal(32'h3004); step();
      o_lw (32'h3008); I_flush = 1'b1; step();
      I_flush = 1'b0; I_valid = 1'b0;
      chk("flush_full_valid", {31'd0, O_valid}, 32'd0);
      chk("flush_full_ready", {31'd0, O_ready}, 32'd1);

      // flush in ONE while O_ready is high: offered instruction must be dropped
      o_add(32'h3100); step();
      o_jal(32'h3104); I_flush = 1'b1; step();
      I_flush = 1'b0; I_valid = 1'b0;
      chk("flush_one_valid", {31'd0, O_valid}, 32'd0);
      I_ready = 1'b1;
      o_srai(32'h3200); step();
      I_valid = 1'b0;
      step();
      chk("flush_issued", issued, 32'd8);

      // asynchronous reset while holding a beq
      I_ready = 1'b0;
      o_beq(32'h4000); step();
      I_valid = 1'b0;
      chk("beq_held", O_instr, 32'h00000063);
      chk("beq_immsel", {29'd0, O_immsel}, 32'd2);
      #2 I_rst = 1'b1;
      #1;
      chk("arst_valid", {31'd0, O_valid}, 32'd0);
      chk("arst_ready", {31'd0, O_ready}, 32'd1);
      chk("arst_instr", O_instr, 32'd0);
      chk("arst_pc", O_pc, 32'd0);
      chk("arst_ctrl", {17'd0, O_immsel, O_useimm, O_regwrite, O_rd, O_rs1, O_illegal}, 32'd0);
      step();
      I_rst = 1'b0;
      I_ready = 1'b1;
      o_lui(32'h5000);
      step();
      I_valid = 1'b0;
      chk("post_rst_accept", {31'd0, O_valid}, 32'd1);
      step();

      // unknown opcode
      o_bad(32'h6000); step();
      I_valid = 1'b0;
      chk("bad_illegal", {31'd0, O_illegal}, {31'd0, ILL});
      chk("bad_regwrite", {31'd0, O_regwrite}, 32'd0);
      step(); step();

      chk("end_issued", issued, 32'd10);
      chk("end_queue", sbq.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
